mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 25 ++
 rtl/mem_arb_prio.sv | 50 +++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
//   state_t  : sequencer states IDLE/BUSY/RESP
//   owner_t  : requester encoding, instruction fetch = 0, data port = 1
//   DEF_*    : default parameter values used by mem_arbiter and mem_arb_prio
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int DEF_MAX_DATA_STREAK = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus between the arbiter and the single-ported cache/memory system.
//   master : arbiter side, drives address/data/op, receives data/done/stall/hit
//   slave  : memory side, the mirror image
interface mem_arbiter_if;

  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_data_out;
  logic        mem_done;
  logic        mem_stall;
  logic        mem_hit;

  modport master (
    output mem_addr, mem_data_in, mem_rd, mem_wr,
    input  mem_data_out, mem_done, mem_stall, mem_hit
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_rd, mem_wr,
    output mem_data_out, mem_done, mem_stall, mem_hit
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection with a starvation bound for the fetch requester.
//   clk, rst_n  : clock, asynchronous active-low reset
//   if_req      : fetch request pending
//   d_req       : data request pending
//   grant_en    : a grant is taken this edge if grant_valid is high
//   grant_owner : requester that would be granted
//   grant_valid : at least one request pending
// Data normally wins. Each data grant made while fetch waits bumps the
// streak; once the streak reaches MAX_DATA_STREAK fetch is forced through.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   grant_en,
  output owner_t grant_owner,
  output logic   grant_valid
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  logic [SW-1:0] streak;
  logic          force_if;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    force_if    = 1'b0;
    grant_owner = OWN_IF;
    grant_valid = if_req || d_req;
    force_if    = if_req && (streak == SW'(MAX_DATA_STREAK));
    if (d_req && !force_if) grant_owner = OWN_D;
  end

  // Streak never passes MAX_DATA_STREAK: at the limit fetch takes the grant
  // and the counter clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_en && grant_valid) begin
      if (grant_owner == OWN_IF || !if_req) streak <= '0;
      else                                  streak <= streak + SW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-ported memory system.
//   clk, rst_n             : clock, asynchronous active-low reset
//   if_rd/if_addr          : fetch read request (held until if_done)
//   if_done/if_data_out/if_hit/if_stall : fetch completion, data, hit, stall
//   d_rd/d_wr/d_addr/d_data_in          : data port request
//   d_done/d_data_out/d_hit/d_stall     : data completion, data, hit, stall
//   mem_bus                : master side of the memory bus
//   err_timeout            : sticky, an access stayed BUSY too long
//   err_illegal            : sticky, d_rd and d_wr both high at grant
// One access in flight at a time: IDLE grants, BUSY holds the bus until
// mem_done, RESP returns a one-cycle done pulse to the owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_rd,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_data_out,
  output logic        if_hit,
  output logic        if_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic        d_done,
  output logic [15:0] d_data_out,
  output logic        d_hit,
  output logic        d_stall,
  mem_arbiter_if.master mem_bus,
  output logic        err_timeout,
  output logic        err_illegal
);

  // Wide enough to hold TIMEOUT_CYCLES + 1 before saturating.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

  state_t        state;
  owner_t        owner;
  owner_t        grant_owner;
  logic          grant_valid;
  logic          grant_en;
  logic          d_req;
  logic [TW-1:0] tcnt;
  logic [15:0]   rdata_q;
  logic          hit_q;

  assign d_req    = d_rd || d_wr;
  assign grant_en = (state == IDLE) && !mem_bus.mem_stall;
  assign if_stall = if_rd && !if_done;
  assign d_stall  = d_req && !d_done;

  mem_arb_prio #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_prio (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_rd),
    .d_req       (d_req),
    .grant_en    (grant_en),
    .grant_owner (grant_owner),
    .grant_valid (grant_valid)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      owner               <= OWN_IF;
      tcnt                <= '0;
      rdata_q             <= '0;
      hit_q               <= 1'b0;
      mem_bus.mem_addr    <= '0;
      mem_bus.mem_data_in <= '0;
      mem_bus.mem_rd      <= 1'b0;
      mem_bus.mem_wr      <= 1'b0;
      if_done             <= 1'b0;
      if_data_out         <= '0;
      if_hit              <= 1'b0;
      d_done              <= 1'b0;
      d_data_out          <= '0;
      d_hit               <= 1'b0;
      err_timeout         <= 1'b0;
      err_illegal         <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_en && grant_valid) begin
            owner <= grant_owner;
            tcnt  <= '0;
            state <= BUSY;
            if (grant_owner == OWN_D) begin
              mem_bus.mem_addr    <= d_addr;
              mem_bus.mem_data_in <= d_data_in;
              // A read+write request is serviced as a write.
              mem_bus.mem_wr      <= d_wr;
              mem_bus.mem_rd      <= !d_wr;
              if (d_rd && d_wr) err_illegal <= 1'b1;
            end else begin
              mem_bus.mem_addr    <= if_addr;
              mem_bus.mem_data_in <= '0;
              mem_bus.mem_wr      <= 1'b0;
              mem_bus.mem_rd      <= 1'b1;
            end
          end
        end
        BUSY: begin
          // tcnt holds BUSY cycles already elapsed; this is cycle tcnt + 1.
          if (tcnt >= TW'(TIMEOUT_CYCLES)) err_timeout <= 1'b1;
          if (tcnt != '1) tcnt <= tcnt + TW'(1);
          if (mem_bus.mem_done) begin
            rdata_q        <= mem_bus.mem_data_out;
            hit_q          <= mem_bus.mem_hit;
            mem_bus.mem_rd <= 1'b0;
            mem_bus.mem_wr <= 1'b0;
            state          <= RESP;
          end
        end
        RESP: begin
          if (owner == OWN_IF) begin
            if_done     <= 1'b1;
            if_data_out <= rdata_q;
            if_hit      <= hit_q;
          end else begin
            d_done     <= 1'b1;
            d_data_out <= rdata_q;
            d_hit      <= hit_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_rd = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_done;
  logic [15:0] if_data_out;
  logic        if_hit;
  logic        if_stall;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_data_in = '0;
  logic        d_done;
  logic [15:0] d_data_out;
  logic        d_hit;
  logic        d_stall;
  logic        err_timeout;
  logic        err_illegal;

  mem_arbiter_if mif();

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_rd       (if_rd),
    .if_addr     (if_addr),
    .if_done     (if_done),
    .if_data_out (if_data_out),
    .if_hit      (if_hit),
    .if_stall    (if_stall),
    .d_rd        (d_rd),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_data_in   (d_data_in),
    .d_done      (d_done),
    .d_data_out  (d_data_out),
    .d_hit       (d_hit),
    .d_stall     (d_stall),
    .mem_bus     (mif),
    .err_timeout (err_timeout),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample/drive point: 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  // mem_done is raised in the lat_cfg-th cycle of an access, so it is
  // sampled lat_cfg edges after the grant edge. Reads return written data
  // or addr ^ 16'hA5A5 for untouched locations.
  int          lat_cfg = 1;
  logic        hit_cfg = 1'b1;
  int          lat_cnt = 0;
  int          hold_err = 0;
  logic [15:0] store [logic [15:0]];
  logic [15:0] grants_q [$];
  logic        g_rd, g_wr;
  logic [15:0] g_addr, g_din;

  initial begin
    mif.mem_done     = 1'b0;
    mif.mem_hit      = 1'b0;
    mif.mem_stall    = 1'b0;
    mif.mem_data_out = '0;
  end

  always @(negedge clk) begin
    if (mif.mem_rd || mif.mem_wr) begin
      lat_cnt = lat_cnt + 1;
      if (lat_cnt == 1) begin
        grants_q.push_back(mif.mem_addr);
        g_rd   = mif.mem_rd;
        g_wr   = mif.mem_wr;
        g_addr = mif.mem_addr;
        g_din  = mif.mem_data_in;
      end else if ({mif.mem_rd, mif.mem_wr, mif.mem_addr, mif.mem_data_in} !=
                   {g_rd, g_wr, g_addr, g_din}) begin
        hold_err = hold_err + 1;
      end
      if (lat_cnt == lat_cfg) begin
        mif.mem_done = 1'b1;
        mif.mem_hit  = hit_cfg;
        if (mif.mem_wr) begin
          store[mif.mem_addr] = mif.mem_data_in;
          mif.mem_data_out    = '0;
        end else if (store.exists(mif.mem_addr)) begin
          mif.mem_data_out = store[mif.mem_addr];
        end else begin
          mif.mem_data_out = mif.mem_addr ^ 16'hA5A5;
        end
      end else begin
        mif.mem_done     = 1'b0;
        mif.mem_hit      = 1'b0;
        mif.mem_data_out = '0;
      end
    end else begin
      lat_cnt          = 0;
      mif.mem_done     = 1'b0;
      mif.mem_hit      = 1'b0;
      mif.mem_data_out = '0;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic        hit;
    int          exp_cyc;
    logic        chk_data;
    logic [15:0] exp_data;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  // Single transaction: drive, count edges to done, check everything, release.
  task automatic run_txn(input string tag, input vec_t v);
    int  cyc;
    int  gsz;
    int  other;
    bit  got;
    lat_cfg = v.lat;
    hit_cfg = v.hit;
    gsz     = grants_q.size();
    if (v.is_d) begin
      d_addr    = v.addr;
      d_data_in = v.wdata;
      d_wr      = v.wr;
      d_rd      = !v.wr;
    end else begin
      if_addr = v.addr;
      if_rd   = 1'b1;
    end
    cyc = 0; got = 0; other = 0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) check({tag, " stall_pending"}, v.is_d ? d_stall : if_stall, 1'b1);
      if (v.is_d ? if_done : d_done) other++;
      if (v.is_d ? d_done : if_done) got = 1;
    end
    check({tag, " latency"}, cyc, v.exp_cyc);
    check({tag, " other_done"}, other, 0);
    check({tag, " stall_at_done"}, v.is_d ? d_stall : if_stall, 1'b0);
    check({tag, " hit"}, v.is_d ? d_hit : if_hit, v.hit);
    if (v.chk_data) check({tag, " data"}, v.is_d ? d_data_out : if_data_out, v.exp_data);
    check({tag, " grants"}, grants_q.size(), gsz + 1);
    check({tag, " mem_op"}, {g_rd, g_wr}, {!v.wr, v.wr});
    check({tag, " mem_addr"}, g_addr, v.addr);
    if (v.wr) check({tag, " mem_data_in"}, g_din, v.wdata);
    check({tag, " err_timeout"}, err_timeout, v.exp_to);
    if_rd = 1'b0;
    d_rd  = 1'b0;
    d_wr  = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_done(input bit want_d, input int limit, output int cyc);
    bit got;
    cyc = 0; got = 0;
    while (!got && cyc < limit) begin
      tick();
      cyc++;
      if (want_d ? d_done : if_done) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL wait_done(%0d): no done within %0d cycles", want_d, limit);
    end
  endtask

  initial begin
    int   cyc;
    int   gsz;
    int   seen;
    vec_t v;

    //          is_d  wr    addr      wdata     lat hit  cyc chk   data      to
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000,  1, 1'b1,  3, 1'b1, 16'hA5B5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF,  1, 1'b1,  3, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000,  2, 1'b1,  4, 1'b1, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h1234, 16'h0000,  5, 1'b0,  7, 1'b1, 16'hB791, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 15, 1'b0, 17, 1'b1, 16'hA6A5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 32, 1'b1, 34, 1'b1, 16'hA5E5, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0060, 16'h0000, 40, 1'b0, 42, 1'b1, 16'hA5C5, 1'b1};

    // Reset values
    repeat (3) tick();
    check("rst mem_rd_wr", {mif.mem_rd, mif.mem_wr}, 2'b00);
    check("rst mem_addr", mif.mem_addr, 16'h0000);
    check("rst dones", {if_done, d_done, if_stall, d_stall}, 4'b0000);
    check("rst data", {if_data_out, d_data_out}, 32'h0);
    check("rst errs", {err_timeout, err_illegal, if_hit, d_hit}, 4'b0000);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle mem_rd_wr", {mif.mem_rd, mif.mem_wr}, 2'b00);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) run_txn($sformatf("v%0d", i), vecs[i]);
    check("table err_illegal", err_illegal, 1'b0);
    check("table d_data_kept", d_data_out, 16'hA5C5);
    check("table if_data_kept", if_data_out, 16'hB791);

    // Simultaneous fetch + data write: data first, fetch after, no back-to-back
    lat_cfg = 1; hit_cfg = 1'b1;
    gsz = grants_q.size();
    if_addr = 16'h1100; if_rd = 1'b1;
    d_addr = 16'h0020; d_data_in = 16'hBEEF; d_wr = 1'b1;
    wait_done(1'b1, 50, cyc);
    check("sim d_first_latency", cyc, 3);
    check("sim if_not_yet", if_done, 1'b0);
    check("sim mem_wr", {g_rd, g_wr}, 2'b01);
    check("sim mem_data_in", g_din, 16'hBEEF);
    d_wr = 1'b0;
    wait_done(1'b0, 50, cyc);
    check("sim if_after_d", cyc, 3);
    check("sim if_data", if_data_out, 16'h1100 ^ 16'hA5A5);
    check("sim grant_order", (grants_q.size() == gsz + 2) ? {grants_q[gsz], grants_q[gsz+1]} : 32'h0,
          {16'h0020, 16'h1100});
    if_rd = 1'b0;
    tick(); tick();

    // Starvation bound: D,D,D,D,IF,D
    gsz = grants_q.size();
    if_addr = 16'h1400; if_rd = 1'b1;
    d_addr = 16'h0200; d_rd = 1'b1;
    wait_done(1'b0, 200, cyc);
    if_rd = 1'b0;
    wait_done(1'b1, 50, cyc);
    d_rd = 1'b0;
    tick(); tick(); tick();
    check("starve grant_count", grants_q.size(), gsz + 6);
    for (int i = 0; i < 6; i++)
      if (gsz + i < grants_q.size())
        check($sformatf("starve grant%0d", i), grants_q[gsz+i], (i == 4) ? 16'h1400 : 16'h0200);

    // Illegal op: serviced as a write, flag set
    check("ill before", err_illegal, 1'b0);
    d_addr = 16'h0050; d_data_in = 16'h1234; d_rd = 1'b1; d_wr = 1'b1;
    wait_done(1'b1, 50, cyc);
    check("ill latency", cyc, 3);
    check("ill mem_op", {g_rd, g_wr}, 2'b01);
    check("ill flag", err_illegal, 1'b1);
    d_rd = 1'b0; d_wr = 1'b0;
    tick(); tick();
    check("ill sticky", err_illegal, 1'b1);
    v = '{1'b1, 1'b0, 16'h0050, 16'h0000, 1, 1'b1, 3, 1'b1, 16'h1234, 1'b1};
    run_txn("ill readback", v);

    // mem_stall holds off the grant; dropped request is never granted
    gsz = grants_q.size();
    mif.mem_stall = 1'b1;
    if_addr = 16'h1300; if_rd = 1'b1;
    repeat (4) tick();
    check("stall no_grant", {mif.mem_rd, mif.mem_wr}, 2'b00);
    check("stall if_stall", if_stall, 1'b1);
    mif.mem_stall = 1'b0;
    wait_done(1'b0, 50, cyc);
    check("stall release_latency", cyc, 3);
    check("stall data", if_data_out, 16'hB6A5);
    if_rd = 1'b0;
    tick(); tick();
    mif.mem_stall = 1'b1;
    d_addr = 16'h0080; d_rd = 1'b1;
    tick(); tick();
    d_rd = 1'b0;
    mif.mem_stall = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (d_done || mif.mem_rd || mif.mem_wr) seen++;
    end
    check("drop no_activity", seen, 0);
    check("drop grant_count", grants_q.size(), gsz + 1);

    // Reset in BUSY
    lat_cfg = 10;
    d_addr = 16'h0070; d_rd = 1'b1;
    repeat (3) tick();
    check("rstmid busy_rd", mif.mem_rd, 1'b1);
    rst_n = 1'b0;
    d_rd  = 1'b0;
    #1;
    check("rstmid mem_rd_wr", {mif.mem_rd, mif.mem_wr}, 2'b00);
    check("rstmid outs", {if_done, d_done, if_stall, d_stall, if_hit, d_hit}, 6'b0);
    check("rstmid data", {if_data_out, d_data_out, mif.mem_addr}, 48'h0);
    check("rstmid errs", {err_timeout, err_illegal}, 2'b00);
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (d_done || if_done || mif.mem_rd) seen++;
    end
    check("rstmid no_done", seen, 0);
    v = '{1'b0, 1'b0, 16'h1234, 16'h0000, 1, 1'b1, 3, 1'b1, 16'hB791, 1'b0};
    run_txn("rstmid after", v);

    check("bus hold", hold_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
